viterbi_core_arbiter: RTL and testbench

- Shares one HLS ATSC Viterbi decoder core (32-bit AXI-Stream in/out, packet-delimited by TLAST) between NUM_REQ requester streams.
- Arbitration is round-robin at whole-packet granularity: a granted requester owns the core input until its TLAST handshake.
- A tag FIFO records the grant order. Core output packets are steered back to the requester that issued the matching input packet.
- Sits in the compute-engine clock domain, between the AXI wrapper fan-out and the decoder core.

---
 rtl/viterbi_core_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_viterbi_core_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_core_arbiter.sv
// Round-robin, whole-packet sharing of one AXI-Stream decoder core; a tag FIFO steers core output
// back to the issuing requester. Define VITERBI_ARB_STATS_EN to add pkt_count / stall_cycles.
module viterbi_core_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ*DATA_W-1:0]   s_req_tdata,
  input  logic [NUM_REQ-1:0]          s_req_tvalid,
  input  logic [NUM_REQ-1:0]          s_req_tlast,
  output logic [NUM_REQ-1:0]          s_req_tready,
  output logic [DATA_W-1:0]           core_in_TDATA,
  output logic                        core_in_TVALID,
  output logic                        core_in_TLAST,
  input  logic                        core_in_TREADY,
  input  logic [DATA_W-1:0]           core_out_TDATA,
  input  logic                        core_out_TVALID,
  input  logic                        core_out_TLAST,
  output logic                        core_out_TREADY,
  output logic [NUM_REQ*DATA_W-1:0]   m_rsp_tdata,
  output logic [NUM_REQ-1:0]          m_rsp_tvalid,
  output logic [NUM_REQ-1:0]          m_rsp_tlast,
  input  logic [NUM_REQ-1:0]          m_rsp_tready,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        err_orphan
`ifdef VITERBI_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]       pkt_count,
  output logic [31:0]                 stall_cycles
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [GW-1:0]                grant_q, grant_d, last_grant_q, last_grant_d;
  logic [TAG_DEPTH-1:0][GW-1:0] tag_mem_q, tag_mem_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         err_orphan_q, err_orphan_d;

  logic          fifo_full, fifo_empty, push, pop, in_last_hs, arb_found;
  logic [GW-1:0] arb_lane, head;

  assign fifo_full  = (cnt_q == CW'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];
  assign in_last_hs = (state_q == BUSY) && core_in_TVALID && core_in_TREADY && core_in_TLAST;
  assign push       = (state_q == IDLE) && arb_found && !fifo_full;
  assign pop        = !fifo_empty && core_out_TVALID && core_out_TREADY && core_out_TLAST;

  // Scan starts one past the lane that most recently finished a packet.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_lane  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_found && s_req_tvalid[idx]) begin
        arb_found = 1'b1;
        arb_lane  = GW'(idx);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      tag_mem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (push) begin
        grant_d = arb_lane;
        state_d = BUSY;
      end
      BUSY: if (in_last_hs) begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    err_orphan_d = err_orphan_q | (fifo_empty & core_out_TVALID);
    if (push) begin
      tag_mem_d[wr_ptr_q] = arb_lane;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Granted lane passes straight through; ready is never a function of the same lane's valid.
  always_comb begin
    core_in_TDATA  = '0;
    core_in_TVALID = 1'b0;
    core_in_TLAST  = 1'b0;
    s_req_tready   = '0;
    if (state_q == BUSY) begin
      core_in_TDATA         = s_req_tdata[int'(grant_q)*DATA_W +: DATA_W];
      core_in_TVALID        = s_req_tvalid[grant_q];
      core_in_TLAST         = s_req_tlast[grant_q];
      s_req_tready[grant_q] = core_in_TREADY;
    end
  end

  assign core_out_TREADY = !fifo_empty && m_rsp_tready[head];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    logic sel;
    assign sel                            = !fifo_empty && (head == GW'(i));
    assign m_rsp_tvalid[i]                = sel & core_out_TVALID;
    assign m_rsp_tlast[i]                 = sel & core_out_TLAST;
    assign m_rsp_tdata[i*DATA_W +: DATA_W] = sel ? core_out_TDATA : '0;
  end

  assign outstanding = cnt_q;
  assign err_orphan  = err_orphan_q;

`ifdef VITERBI_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] pkt_count_q, pkt_count_d;
  logic [31:0]              stall_cycles_q, stall_cycles_d;

  always_comb begin
    pkt_count_d    = pkt_count_q;
    stall_cycles_d = stall_cycles_q;
    if (in_last_hs) pkt_count_d[grant_q] = pkt_count_q[grant_q] + 32'd1;
    if ((state_q == IDLE) && (|s_req_tvalid) && fifo_full && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      pkt_count_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      pkt_count_q    <= pkt_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pkt_count    = pkt_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_viterbi_core_arbiter.sv
// Directed bench for viterbi_core_arbiter: requester/core behavioural models plus a per-lane
// response scoreboard filled as packets are queued.
module tb_viterbi_core_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [63:0] s_req_tdata = '0;
  logic [1:0]  s_req_tvalid = '0;
  logic [1:0]  s_req_tlast = '0;
  logic [1:0]  s_req_tready;
  logic [31:0] core_in_TDATA;
  logic        core_in_TVALID, core_in_TLAST;
  logic        core_in_TREADY = 1'b0;
  logic [31:0] core_out_TDATA = '0;
  logic        core_out_TVALID = 1'b0;
  logic        core_out_TLAST = 1'b0;
  logic        core_out_TREADY;
  logic [63:0] m_rsp_tdata;
  logic [1:0]  m_rsp_tvalid, m_rsp_tlast;
  logic [1:0]  m_rsp_tready = 2'b11;
  logic [1:0]  outstanding;
  logic        err_orphan;
`ifdef VITERBI_ARB_STATS_EN
  logic [63:0] pkt_count;
  logic [31:0] stall_cycles;
`endif

  viterbi_core_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_req_tdata(s_req_tdata), .s_req_tvalid(s_req_tvalid), .s_req_tlast(s_req_tlast),
    .s_req_tready(s_req_tready),
    .core_in_TDATA(core_in_TDATA), .core_in_TVALID(core_in_TVALID), .core_in_TLAST(core_in_TLAST),
    .core_in_TREADY(core_in_TREADY),
    .core_out_TDATA(core_out_TDATA), .core_out_TVALID(core_out_TVALID),
    .core_out_TLAST(core_out_TLAST), .core_out_TREADY(core_out_TREADY),
    .m_rsp_tdata(m_rsp_tdata), .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tlast(m_rsp_tlast),
    .m_rsp_tready(m_rsp_tready),
    .outstanding(outstanding), .err_orphan(err_orphan)
`ifdef VITERBI_ARB_STATS_EN
    , .pkt_count(pkt_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] src_q0[$], src_q1[$], exp_q0[$], exp_q1[$], core_q[$], chk_in[$];
  int          core_due[$];
  int          cyc = 0, cin_cnt = 0, last_cyc = 0;
  bit          out_hold = 0, orphan_inj = 0, gap_chk = 0, prev_last = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #3;
  endtask

  // Queue a packet on a lane; its beats are expected back on the same lane in order.
  task automatic send(input int lane, input logic [31:0] base, input int n, input bit order);
    logic [32:0] beat;
    for (int b = 0; b < n; b++) begin
      beat = {(b == n - 1), base + 32'(b)};
      if (lane == 0) begin src_q0.push_back(beat); exp_q0.push_back(beat); end
      else           begin src_q1.push_back(beat); exp_q1.push_back(beat); end
      if (order) chk_in.push_back(beat);
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ap_clk);
      if (src_q0.size() == 0 && src_q1.size() == 0 && exp_q0.size() == 0 &&
          exp_q1.size() == 0 && core_q.size() == 0 && outstanding == 2'd0) done = 1;
    end
    chk(tag, done, 1);
  endtask

  // Requester sources, identity core (3-cycle latency) and response checker.
  always begin : bfm
    bit          rst_s, hold_s, inj_s, hs0, hs1, hs_cin, hs_cout;
    logic [32:0] cin;
    @(negedge ap_clk);
    rst_s   = ap_rst_n;
    hold_s  = out_hold;
    inj_s   = orphan_inj;
    hs0     = s_req_tvalid[0] & s_req_tready[0];
    hs1     = s_req_tvalid[1] & s_req_tready[1];
    hs_cin  = core_in_TVALID & core_in_TREADY;
    hs_cout = core_out_TVALID & core_out_TREADY;
    cin     = {core_in_TLAST, core_in_TDATA};
    if (rst_s) begin
      if (m_rsp_tvalid[0] && m_rsp_tready[0]) begin
        if (exp_q0.size() == 0) chk("rsp0_extra", m_rsp_tvalid[0], 0);
        else chk("rsp0", {m_rsp_tlast[0], m_rsp_tdata[31:0]}, exp_q0.pop_front());
      end
      if (m_rsp_tvalid[1] && m_rsp_tready[1]) begin
        if (exp_q1.size() == 0) chk("rsp1_extra", m_rsp_tvalid[1], 0);
        else chk("rsp1", {m_rsp_tlast[1], m_rsp_tdata[63:32]}, exp_q1.pop_front());
      end
      if (hs_cin && chk_in.size() > 0) chk("core_in_order", cin, chk_in.pop_front());
      if (hs_cin && gap_chk && prev_last) chk("core_in_gap", cyc - last_cyc, 2);
      if (hs_cin) begin prev_last = core_in_TLAST; last_cyc = cyc; end
      if (!gap_chk) prev_last = 0;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
    if (!rst_s) begin
      src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
      core_q.delete(); core_due.delete(); chk_in.delete();
    end else begin
      if (hs0) void'(src_q0.pop_front());
      if (hs1) void'(src_q1.pop_front());
      if (hs_cout) begin void'(core_q.pop_front()); void'(core_due.pop_front()); end
      if (hs_cin) begin core_q.push_back(cin); core_due.push_back(cyc + 2); cin_cnt++; end
    end
    s_req_tvalid[0]    = src_q0.size() > 0;
    s_req_tdata[31:0]  = (src_q0.size() > 0) ? src_q0[0][31:0] : '0;
    s_req_tlast[0]     = (src_q0.size() > 0) ? src_q0[0][32] : 1'b0;
    s_req_tvalid[1]    = src_q1.size() > 0;
    s_req_tdata[63:32] = (src_q1.size() > 0) ? src_q1[0][31:0] : '0;
    s_req_tlast[1]     = (src_q1.size() > 0) ? src_q1[0][32] : 1'b0;
    if (inj_s) begin
      core_out_TVALID = 1'b1; core_out_TDATA = 32'hDEAD_0000; core_out_TLAST = 1'b1;
    end else if (!hold_s && core_q.size() > 0 && cyc >= core_due[0]) begin
      core_out_TVALID = 1'b1; core_out_TDATA = core_q[0][31:0]; core_out_TLAST = core_q[0][32];
    end else begin
      core_out_TVALID = 1'b0; core_out_TDATA = '0; core_out_TLAST = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int base;
    ap_rst_n = 0; core_in_TREADY = 1; m_rsp_tready = 2'b11;
    repeat (3) tick();
    @(negedge ap_clk);
    chk("rst_outs", {|core_in_TDATA, core_in_TVALID, core_in_TLAST, |s_req_tready, core_out_TREADY,
                     |m_rsp_tdata, |m_rsp_tvalid, |m_rsp_tlast}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_orphan, 0);
    tick(); ap_rst_n = 1;

    // Single 4-beat packet on lane 0 through the loopback core
    send(0, 32'h0A00_0000, 4, 0);
    drain("t1_drain");
    chk("t1_outstanding", outstanding, 0);
    chk("t1_err", err_orphan, 0);

    // Fresh reset: both lanes contend, grants alternate starting at lane 0
    tick(); ap_rst_n = 0; tick(); tick(); ap_rst_n = 1;
    gap_chk = 1;
    send(0, 32'hB000_0000, 2, 1); send(1, 32'hB100_0000, 2, 1);
    send(0, 32'hB000_0010, 2, 1); send(1, 32'hB100_0010, 2, 1);
    drain("t2_drain");
    chk("t2_order_done", chk_in.size(), 0);
    gap_chk = 0;

    // Tag FIFO full: third grant withheld until one output packet drains
    tick(); out_hold = 1;
    send(0, 32'hC000_0000, 2, 0); send(1, 32'hC100_0000, 2, 0); send(0, 32'hC000_0010, 2, 0);
    repeat (15) tick();
    @(negedge ap_clk);
    chk("t3_full_outstanding", outstanding, 2);
    chk("t3_withheld_valid", core_in_TVALID, 0);
    chk("t3_withheld_ready", s_req_tready, 0);
    tick(); out_hold = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge ap_clk);
      if (outstanding == 2'd1) got = 1;
    end
    chk("t3_pop_seen", got, 1);
    @(negedge ap_clk);
    chk("t3_regrant_valid", core_in_TVALID, 1);
    chk("t3_regrant_outstanding", outstanding, 2);
    drain("t3_drain");

    // Response backpressure on head lane 1
    tick(); m_rsp_tready = 2'b01;
    send(1, 32'hE100_0000, 2, 0);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge ap_clk);
      if (core_out_TVALID) got = 1;
    end
    chk("t5_core_valid_seen", got, 1);
    chk("t5_core_ready", core_out_TREADY, 0);
    chk("t5_rsp_valid", m_rsp_tvalid, 2'b10);
    repeat (4) @(negedge ap_clk);
    chk("t5_hold_data", {m_rsp_tlast[1], m_rsp_tdata[63:32]}, {1'b0, 32'hE100_0000});
    chk("t5_core_ready_held", core_out_TREADY, 0);
    tick(); m_rsp_tready = 2'b11;
    drain("t5_drain");

    // Orphan core output with no tag pending
    tick(); orphan_inj = 1;
    @(negedge ap_clk);
    chk("t4_err_before", err_orphan, 0);
    @(negedge ap_clk);
    chk("t4_core_ready", core_out_TREADY, 0);
    chk("t4_rsp_valid", m_rsp_tvalid, 0);
    @(negedge ap_clk);
    chk("t4_err_set", err_orphan, 1);
    tick(); orphan_inj = 0;
    repeat (5) tick();
    @(negedge ap_clk);
    chk("t4_err_sticky", err_orphan, 1);
    tick(); ap_rst_n = 0;
    tick();
    @(negedge ap_clk);
    chk("t4_err_cleared", err_orphan, 0);
    tick(); ap_rst_n = 1;

    // Reset in the middle of a 5-beat packet
    send(0, 32'hF000_0000, 5, 0);
    base = cin_cnt;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge ap_clk);
      if (cin_cnt >= base + 2) got = 1;
    end
    chk("t6_two_beats", got, 1);
    tick(); ap_rst_n = 0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("t6_rst_outs", {|core_in_TDATA, core_in_TVALID, core_in_TLAST, |s_req_tready, core_out_TREADY,
                        |m_rsp_tdata, |m_rsp_tvalid, |m_rsp_tlast}, 0);
    chk("t6_rst_outstanding", outstanding, 0);
    tick(); ap_rst_n = 1;
    send(0, 32'h6000_0000, 1, 1); send(1, 32'h6100_0000, 1, 1);
    drain("t6_drain");
    chk("t6_order_done", chk_in.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
